// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath constants, complex word type and bit-reverse helper
package fft_pkg;

    localparam int IN_WIDTH   = 16;
    localparam int DATA_WIDTH = 21;
    localparam int FRAC_BITS  = 15;
    localparam int LOG2N      = 4;
    localparam int N          = 1 << LOG2N;
    localparam int NPAIR      = N / 2;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    // Reverse the low nbits of idx; nbits must not exceed LOG2N.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx, input int nbits);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            r[i] = idx[nbits-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_buffer_if.sv
// rtl/fft_bitrev_buffer_if.sv - sample input and butterfly pair output handshake bundle
interface fft_bitrev_buffer_if;
    import fft_pkg::*;

    logic signed [IN_WIDTH-1:0]   in_re_i;
    logic signed [IN_WIDTH-1:0]   in_im_i;
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic signed [DATA_WIDTH-1:0] a_re_o;
    logic signed [DATA_WIDTH-1:0] a_im_o;
    logic signed [DATA_WIDTH-1:0] b_re_o;
    logic signed [DATA_WIDTH-1:0] b_im_o;
    logic [LOG2N-2:0]             out_idx_o;
    logic                         out_last_o;
    logic                         out_valid_o;
    logic                         out_ready_i;

    modport master (
        output in_re_i, in_im_i, in_valid_i, out_ready_i,
        input  in_ready_o, a_re_o, a_im_o, b_re_o, b_im_o,
               out_idx_o, out_last_o, out_valid_o
    );

    modport slave (
        input  in_re_i, in_im_i, in_valid_i, out_ready_i,
        output in_ready_o, a_re_o, a_im_o, b_re_o, b_im_o,
               out_idx_o, out_last_o, out_valid_o
    );

endinterface

// File: rtl/fft_buf_bank.sv
// rtl/fft_buf_bank.sv - N-entry complex register file, one write port, two combinational read ports
module fft_buf_bank
    import fft_pkg::*;
(
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [LOG2N-1:0] waddr_i,
    input  cplx_t            wdata_i,
    input  logic [LOG2N-1:0] raddr_a_i,
    input  logic [LOG2N-1:0] raddr_b_i,
    output cplx_t            rdata_a_o,
    output cplx_t            rdata_b_o
);

    cplx_t mem [N];

    // Contents are not reset; the owner's full flag decides when they are meaningful.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem[raddr_a_i];
    assign rdata_b_o = mem[raddr_b_i];

endmodule

// File: rtl/fft_bitrev_buffer.sv
// rtl/fft_bitrev_buffer.sv - ping-pong natural-to-bit-reversed reorder buffer feeding butterfly pairs
module fft_bitrev_buffer
    import fft_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    fft_bitrev_buffer_if.slave bus
);

    localparam logic [LOG2N-1:0] WR_LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-2:0] RD_LAST = (LOG2N-1)'(NPAIR - 1);

    bank_state_t      bank_q [2];
    bank_state_t      bank_d [2];
    logic             wr_bank_q;
    logic             rd_bank_q;
    logic [LOG2N-1:0] wr_cnt_q;
    logic [LOG2N-2:0] rd_cnt_q;

    logic             in_fire;
    logic             out_fire;
    logic             wr_wrap;
    logic             rd_wrap;
    cplx_t            wdata;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    cplx_t            rd_a [2];
    cplx_t            rd_b [2];
    cplx_t            sel_a;
    cplx_t            sel_b;

    // Handshakes depend only on registered state, never on in_valid_i or out_ready_i.
    assign bus.in_ready_o  = (bank_q[wr_bank_q] == BANK_EMPTY);
    assign bus.out_valid_o = (bank_q[rd_bank_q] == BANK_FULL);

    assign in_fire  = bus.in_valid_i && bus.in_ready_o;
    assign out_fire = bus.out_valid_o && bus.out_ready_i;
    assign wr_wrap  = in_fire && (wr_cnt_q == WR_LAST);
    assign rd_wrap  = out_fire && (rd_cnt_q == RD_LAST);

    // Sign-extend into the butterfly word so later stages have growth headroom.
    assign wdata.re = {{(DATA_WIDTH-IN_WIDTH){bus.in_re_i[IN_WIDTH-1]}}, bus.in_re_i};
    assign wdata.im = {{(DATA_WIDTH-IN_WIDTH){bus.in_im_i[IN_WIDTH-1]}}, bus.in_im_i};

    // Pair k reads natural addresses bitrev(2k) and bitrev(2k+1).
    assign addr_a = bitrev({rd_cnt_q, 1'b0}, LOG2N);
    assign addr_b = bitrev({rd_cnt_q, 1'b1}, LOG2N);

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_buf_bank u_bank (
            .clk_i     (clk_i),
            .we_i      (in_fire && (wr_bank_q == 1'(g))),
            .waddr_i   (wr_cnt_q),
            .wdata_i   (wdata),
            .raddr_a_i (addr_a),
            .raddr_b_i (addr_b),
            .rdata_a_o (rd_a[g]),
            .rdata_b_o (rd_b[g])
        );
    end

    // Bank next state: fills on the Nth write, empties on the last pair; set and clear may coincide on different banks.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        for (int b = 0; b < 2; b++) begin
            if (wr_wrap && (wr_bank_q == 1'(b))) begin
                bank_d[b] = BANK_FULL;
            end
            if (rd_wrap && (rd_bank_q == 1'(b))) begin
                bank_d[b] = BANK_EMPTY;
            end
        end
    end

    // Bank state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
        end
    end

    // Write/read counters and bank pointers; a reset discards any partial frame or partial read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            if (in_fire) begin
                wr_cnt_q <= wr_cnt_q + LOG2N'(1);
                if (wr_wrap) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
            if (out_fire) begin
                rd_cnt_q <= rd_cnt_q + (LOG2N-1)'(1);
                if (rd_wrap) begin
                    rd_bank_q <= ~rd_bank_q;
                end
            end
        end
    end

    assign sel_a = rd_bank_q ? rd_a[1] : rd_a[0];
    assign sel_b = rd_bank_q ? rd_b[1] : rd_b[0];

    assign bus.a_re_o     = bus.out_valid_o ? sel_a.re : '0;
    assign bus.a_im_o     = bus.out_valid_o ? sel_a.im : '0;
    assign bus.b_re_o     = bus.out_valid_o ? sel_b.re : '0;
    assign bus.b_im_o     = bus.out_valid_o ? sel_b.im : '0;
    assign bus.out_idx_o  = bus.out_valid_o ? rd_cnt_q : '0;
    assign bus.out_last_o = bus.out_valid_o && (rd_cnt_q == RD_LAST);

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// tb/tb_fft_bitrev_buffer.sv - scoreboard bench for the bit-reverse reorder buffer
module tb_fft_bitrev_buffer;
    import fft_pkg::*;

    typedef struct packed {
        logic [20:0] a_re;
        logic [20:0] a_im;
        logic [20:0] b_re;
        logic [20:0] b_im;
        logic [2:0]  idx;
        logic        last;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_bitrev_buffer_if bus ();

    fft_bitrev_buffer dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    pair_t       sb [$];
    logic [20:0] m_re [16];
    logic [20:0] m_im [16];
    int          m_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    function automatic logic [20:0] sext(input logic [15:0] v);
        int s;
        s = $signed(v);
        return s[20:0];
    endfunction

    task automatic model_push(input logic [15:0] re, input logic [15:0] im);
        pair_t      p;
        logic [3:0] ia;
        logic [3:0] ib;
        m_re[m_cnt] = sext(re);
        m_im[m_cnt] = sext(im);
        m_cnt++;
        if (m_cnt == 16) begin
            m_cnt = 0;
            for (int k = 0; k < 8; k++) begin
                ia     = rev4(4'(2 * k));
                ib     = rev4(4'(2 * k + 1));
                p.a_re = m_re[ia];
                p.a_im = m_im[ia];
                p.b_re = m_re[ib];
                p.b_im = m_im[ib];
                p.idx  = 3'(k);
                p.last = (k == 7);
                sb.push_back(p);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] re, input logic [15:0] im, input logic rdy,
                         output logic in_fire, output logic out_fire, output pair_t got);
        @(negedge clk);
        bus.in_valid_i  = v;
        bus.in_re_i     = re;
        bus.in_im_i     = im;
        bus.out_ready_i = rdy;
        in_fire  = v && bus.in_ready_o;
        out_fire = bus.out_valid_o && rdy;
        got.a_re = bus.a_re_o;
        got.a_im = bus.a_im_o;
        got.b_re = bus.b_re_o;
        got.b_im = bus.b_im_o;
        got.idx  = bus.out_idx_o;
        got.last = bus.out_last_o;
        if (in_fire) model_push(re, im);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid_i = 1'b0; bus.in_re_i = '0; bus.in_im_i = '0; bus.out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready_o); end
        n_cmp++;
        if ({bus.out_valid_o, bus.out_last_o, bus.out_idx_o} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl got=%b exp=00000", {bus.out_valid_o, bus.out_last_o, bus.out_idx_o});
        end
        n_cmp++;
        if ({bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o} !== 84'h0) begin
            n_bad++; $display("FAIL reset_data got=%h exp=0", {bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        logic inf, outf, fired15;
        pair_t got, exp;
        int sent;
        sent = 0; fired15 = 1'b0;
        for (int cyc = 0; cyc < 200 && (sent < 16 || sb.size() != 0); cyc++) begin
            drive(sent < 16, 16'(sent), 16'(-sent), 1'b1, inf, outf, got);
            if (fired15) begin
                n_cmp++; fired15 = 1'b0;
                if (bus.out_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_latency got=%b exp=1", bus.out_valid_o); end
            end
            if (inf && sent == 15) begin
                n_cmp++; fired15 = 1'b1;
                if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got=%b exp=0", bus.out_valid_o); end
            end
            if (inf) sent++;
            if (outf) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL single_extra got=%h exp=none", got); end
                else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin n_bad++; $display("FAIL single_pair got=%h exp=%h", got, exp); end
                    if (got.idx == 3'd0) begin
                        n_cmp++;
                        if ({got.a_re, got.a_im, got.b_re, got.b_im, got.last} !== {21'sd0, 21'sd0, 21'sd8, -21'sd8, 1'b0}) begin
                            n_bad++; $display("FAIL single_k0 got=%h", got);
                        end
                    end
                    if (got.idx == 3'd1) begin
                        n_cmp++;
                        if ({got.a_re, got.a_im, got.b_re, got.b_im, got.last} !== {21'sd4, -21'sd4, 21'sd12, -21'sd12, 1'b0}) begin
                            n_bad++; $display("FAIL single_k1 got=%h", got);
                        end
                    end
                    if (got.idx == 3'd7) begin
                        n_cmp++;
                        if ({got.a_re, got.a_im, got.b_re, got.b_im, got.last} !== {21'sd7, -21'sd7, 21'sd15, -21'sd15, 1'b1}) begin
                            n_bad++; $display("FAIL single_k7 got=%h", got);
                        end
                    end
                end
            end
        end
        n_cmp++;
        if (sent < 16 || sb.size() != 0) begin n_bad++; $display("FAIL single_timeout sent=%0d pending=%0d exp=16/0", sent, sb.size()); end
    endtask

    task automatic test_sign_ext();
        logic inf, outf;
        logic [15:0] re, im;
        pair_t got, exp;
        int sent;
        sent = 0;
        for (int cyc = 0; cyc < 200 && (sent < 16 || sb.size() != 0); cyc++) begin
            if (sent == 0)      begin re = 16'h8000; im = 16'h7FFF; end
            else if (sent == 8) begin re = 16'h7FFF; im = 16'h8000; end
            else                begin re = 16'(sent * 4099); im = 16'(sent * 30011); end
            drive(sent < 16, re, im, 1'b1, inf, outf, got);
            if (inf) sent++;
            if (outf) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL sext_extra got=%h exp=none", got); end
                else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin n_bad++; $display("FAIL sext_pair got=%h exp=%h", got, exp); end
                    if (got.idx == 3'd0) begin
                        n_cmp++;
                        if ({got.a_re, got.a_im, got.b_re, got.b_im} !== {21'h1F8000, 21'h007FFF, 21'h007FFF, 21'h1F8000}) begin
                            n_bad++; $display("FAIL sext_values got=%h exp=1f8000/007fff/007fff/1f8000", got);
                        end
                    end
                end
            end
        end
        n_cmp++;
        if (sent < 16 || sb.size() != 0) begin n_bad++; $display("FAIL sext_timeout sent=%0d pending=%0d exp=16/0", sent, sb.size()); end
    endtask

    task automatic test_backpressure();
        logic inf, outf, seen_last, chk_free, rdy;
        pair_t got, exp;
        int sent;
        sent = 0; seen_last = 1'b0; chk_free = 1'b0;
        for (int cyc = 0; cyc < 400 && (sent < 48 || sb.size() != 0); cyc++) begin
            rdy = (cyc >= 50);
            drive(sent < 48, 16'(sent * 37 + 5), 16'(sent * 211 - 900), rdy, inf, outf, got);
            if (cyc == 20 || cyc == 49) begin
                n_cmp++;
                if (sb.size() == 0 || bus.out_valid_o !== 1'b1 || got !== sb[0]) begin
                    n_bad++; $display("FAIL bp_hold cyc=%0d got=%h valid=%b", cyc, got, bus.out_valid_o);
                end
            end
            if (cyc == 49) begin
                n_cmp++;
                if (sent != 32 || bus.in_ready_o !== 1'b0) begin
                    n_bad++; $display("FAIL bp_stall accepted=%0d in_ready=%b exp=32/0", sent, bus.in_ready_o);
                end
            end
            if (chk_free) begin
                n_cmp++; chk_free = 1'b0;
                if (bus.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_free got=%b exp=1", bus.in_ready_o); end
            end
            if (inf) sent++;
            if (outf) begin
                if (got.last && !seen_last) begin
                    n_cmp++; seen_last = 1'b1; chk_free = 1'b1;
                    if (bus.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_early_free got=%b exp=0", bus.in_ready_o); end
                end
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL bp_extra got=%h exp=none", got); end
                else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin n_bad++; $display("FAIL bp_pair got=%h exp=%h", got, exp); end
                end
            end
        end
        n_cmp++;
        if (sent < 48 || sb.size() != 0) begin n_bad++; $display("FAIL bp_timeout sent=%0d pending=%0d exp=48/0", sent, sb.size()); end
    endtask

    task automatic test_streaming();
        logic inf, outf;
        pair_t got, exp;
        int sent, drops, pops;
        sent = 0; drops = 0; pops = 0;
        for (int cyc = 0; cyc < 300 && (sent < 64 || sb.size() != 0); cyc++) begin
            drive(sent < 64, 16'($urandom), 16'($urandom), 1'b1, inf, outf, got);
            if (sent < 64 && bus.in_ready_o !== 1'b1) drops++;
            if (inf) sent++;
            if (outf) begin
                pops++;
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL stream_extra got=%h exp=none", got); end
                else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin n_bad++; $display("FAIL stream_pair got=%h exp=%h", got, exp); end
                end
            end
        end
        n_cmp++;
        if (drops != 0) begin n_bad++; $display("FAIL stream_ready_drops got=%0d exp=0", drops); end
        n_cmp++;
        if (pops != 32 || sent != 64) begin n_bad++; $display("FAIL stream_count pops=%0d sent=%0d exp=32/64", pops, sent); end
    endtask

    task automatic test_random();
        logic inf, outf;
        logic [15:0] re, im;
        pair_t got, exp;
        int sent, pops;
        sent = 0; pops = 0;
        re = 16'($urandom); im = 16'($urandom);
        for (int cyc = 0; cyc < 3000 && (sent < 160 || sb.size() != 0); cyc++) begin
            drive((sent < 160) && ($urandom_range(2) != 0), re, im, ($urandom_range(1) != 0), inf, outf, got);
            if (inf) begin
                sent++;
                re = 16'($urandom); im = 16'($urandom);
            end
            if (outf) begin
                pops++;
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL rand_extra got=%h exp=none", got); end
                else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin n_bad++; $display("FAIL rand_pair got=%h exp=%h", got, exp); end
                end
            end
        end
        n_cmp++;
        if (pops != 80 || sent != 160 || sb.size() != 0) begin
            n_bad++; $display("FAIL rand_count pops=%0d sent=%0d pending=%0d exp=80/160/0", pops, sent, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        logic inf, outf;
        pair_t got, exp;
        int sent, pops;
        sent = 0; pops = 0;
        for (int cyc = 0; cyc < 200 && sent < 25; cyc++) begin
            drive(1'b1, 16'(sent + 100), 16'(sent - 100), (pops < 3), inf, outf, got);
            if (inf) sent++;
            if (outf) begin
                pops++;
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL rmid_extra got=%h exp=none", got); end
                else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin n_bad++; $display("FAIL rmid_pair got=%h exp=%h", got, exp); end
                end
            end
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        n_cmp++;
        if (bus.out_valid_o !== 1'b1 || bus.out_idx_o !== 3'd3) begin
            n_bad++; $display("FAIL rmid_pre valid=%b idx=%0d exp=1/3", bus.out_valid_o, bus.out_idx_o);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready_o, bus.out_valid_o, bus.out_last_o, bus.out_idx_o} !== 6'b100000) begin
            n_bad++; $display("FAIL rmid_ctrl got=%b exp=100000", {bus.in_ready_o, bus.out_valid_o, bus.out_last_o, bus.out_idx_o});
        end
        n_cmp++;
        if ({bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o} !== 84'h0) begin
            n_bad++; $display("FAIL rmid_data got=%h exp=0", {bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o});
        end
        sb.delete();
        m_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sent = 0; pops = 0;
        for (int cyc = 0; cyc < 200 && (sent < 16 || sb.size() != 0); cyc++) begin
            drive(sent < 16, 16'(sent * 513 + 7), 16'(~sent), 1'b1, inf, outf, got);
            if (inf) sent++;
            if (outf) begin
                pops++;
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL rmid_post_extra got=%h exp=none", got); end
                else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin n_bad++; $display("FAIL rmid_post_pair got=%h exp=%h", got, exp); end
                end
            end
        end
        n_cmp++;
        if (pops != 8 || sent != 16) begin n_bad++; $display("FAIL rmid_post_count pops=%0d sent=%0d exp=8/16", pops, sent); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_sign_ext();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
